// File: rtl/rep_mul_pkg.sv
// Shared types for the repeated-addition multiplier: FSM state encoding and
// the product-width helper used by the interface, top level and bench.
package rep_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int PROD_W(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/rep_add_multiplier_if.sv
// Start/done handshake bundle between the host FSM (master) and the
// repeated-addition multiplier (slave).
interface rep_add_multiplier_if #(
  parameter int WIDTH = 16
) ();
  import rep_mul_pkg::*;

  logic                       start;
  logic [WIDTH-1:0]           a;
  logic [WIDTH-1:0]           b;
  logic                       busy;
  logic                       done;
  logic [PROD_W(WIDTH)-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/rep_mul_cntr.sv
// WIDTH-bit loadable down-counter with synchronous reset; it saturates at
// zero so the iteration count can never wrap.
module rep_mul_cntr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/rep_add_multiplier.sv
// Unsigned multiplier computing a*b by repeated addition under a start/done
// handshake. Define REP_MUL_OPSWAP_EN to iterate over the smaller operand.
module rep_add_multiplier
  import rep_mul_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rep_add_multiplier_if.slave  bus
);

  localparam int PW = PROD_W(WIDTH);

  state_e           state_r;
  state_e           next_state_s;
  logic             accept_s;
  logic             run_s;
  logic             cnt_zero_s;
  logic [WIDTH-1:0] addend_in_s;
  logic [WIDTH-1:0] count_in_s;
  logic [WIDTH-1:0] addend_r;
  logic [PW-1:0]    acc_r;
  logic [PW-1:0]    product_r;
  logic             busy_s;
  logic             done_s;
  logic             busy_r;
  logic             done_r;

  assign run_s    = (state_r == ST_RUN);
  assign accept_s = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

`ifdef REP_MUL_OPSWAP_EN
  // Larger operand becomes the addend so the loop runs min(a,b) times.
  always_comb begin
    addend_in_s = bus.a;
    count_in_s  = bus.b;
    if (bus.a < bus.b) begin
      addend_in_s = bus.b;
      count_in_s  = bus.a;
    end else begin
      addend_in_s = bus.a;
      count_in_s  = bus.b;
    end
  end
`else
  // Operands pass straight through: a is added b times.
  always_comb begin
    addend_in_s = bus.a;
    count_in_s  = bus.b;
  end
`endif

  rep_mul_cntr #(.WIDTH(WIDTH)) u_cntr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .load_val (count_in_s),
    .dec      (run_s),
    .zero     (cnt_zero_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; start is only honoured outside RUN.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: next_state_s = bus.start  ? ST_RUN  : ST_IDLE;
      ST_RUN:  next_state_s = cnt_zero_s ? ST_DONE : ST_RUN;
      ST_DONE: next_state_s = bus.start  ? ST_RUN  : ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the next state so the flops track the state.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (next_state_s)
      ST_RUN:  busy_s = 1'b1;
      ST_DONE: done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Output flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Datapath: addend/accumulator load, add loop, and product capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addend_r  <= '0;
      acc_r     <= '0;
      product_r <= '0;
    end else if (accept_s) begin
      addend_r  <= addend_in_s;
      acc_r     <= '0;
      product_r <= product_r;
    end else if (run_s && !cnt_zero_s) begin
      addend_r  <= addend_r;
      acc_r     <= acc_r + PW'(addend_r);
      product_r <= product_r;
    end else if (run_s) begin
      addend_r  <= addend_r;
      acc_r     <= acc_r;
      product_r <= acc_r;
    end else begin
      addend_r  <= addend_r;
      acc_r     <= acc_r;
      product_r <= product_r;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_rep_add_multiplier.sv
// Self-checking bench: a WIDTH=16 and a WIDTH=4 instance, table-driven vectors
// plus hand sequences (back-to-back, start noise in RUN, mid-run reset).
module tb_rep_add_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rep_add_multiplier_if #(.WIDTH(16)) m16 ();
  rep_add_multiplier_if #(.WIDTH(4))  m4 ();

  rep_add_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(m16));
  rep_add_multiplier #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(m4));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [63:0] prod;
    string       name;
  } vec_t;

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle (counted from the accepting edge) in which done is expected.
  function automatic int lat_of(input logic [15:0] a, input logic [15:0] b);
`ifdef REP_MUL_OPSWAP_EN
    return ((a < b) ? int'(a) : int'(b)) + 2;
`else
    return int'(b) + 2;
`endif
  endfunction

  task automatic sample(input bit unit, output logic bz, output logic dn, output logic [63:0] pr);
    if (unit) begin
      bz = m4.busy;  dn = m4.done;  pr = 64'(m4.product);
    end else begin
      bz = m16.busy; dn = m16.done; pr = 64'(m16.product);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 with start low.
  task automatic launch(input bit unit, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (unit) begin
      m4.start = 1'b1; m4.a = a[3:0]; m4.b = b[3:0];
    end else begin
      m16.start = 1'b1; m16.a = a; m16.b = b;
    end
    e.prod = 64'(a) * 64'(b);
    e.lat  = lat_of(a, b);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    m4.start  = 1'b0;
    m16.start = 1'b0;
  endtask

  // Watches busy until done; returns at the negedge of the done cycle.
  task automatic finish(input bit unit, input bit noise, input string name);
    exp_t        e;
    int          cyc;
    logic        bz, dn;
    logic [63:0] pr;
    chk({name, " sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cyc = 1;
      while (1) begin
        sample(unit, bz, dn, pr);
        if (dn || cyc > e.lat + 4) break;
        chk({name, " busy_run"}, 64'(bz), 64'd1);
        if (noise) begin
          m16.start = 1'($urandom_range(0, 1));
          m16.a     = 16'($urandom);
          m16.b     = 16'($urandom);
        end
        @(negedge clk);
        cyc++;
      end
      m16.start = 1'b0;
      chk({name, " done"},    64'(dn),  64'd1);
      chk({name, " latency"}, 64'(cyc), 64'(e.lat));
      chk({name, " product"}, pr,       e.prod);
      chk({name, " busy_done"}, 64'(bz), 64'd0);
    end
  endtask

  task automatic idle_chk(input bit unit, input string name, input logic [63:0] held);
    logic bz, dn;
    logic [63:0] pr;
    @(negedge clk);
    sample(unit, bz, dn, pr);
    chk({name, " idle_busy"}, 64'(bz), 64'd0);
    chk({name, " idle_done"}, 64'(dn), 64'd0);
    chk({name, " idle_prod"}, pr, held);
  endtask

  initial begin
    logic seen_done;
    m16.start = 1'b0; m16.a = '0; m16.b = '0;
    m4.start  = 1'b0; m4.a  = '0; m4.b  = '0;

    vecs.push_back('{16'd3,      16'd5,      64'd15,       "3x5"});
    vecs.push_back('{16'd5,      16'd3,      64'd15,       "5x3"});
    vecs.push_back('{16'hFFFF,   16'd0,      64'd0,        "ffffx0"});
    vecs.push_back('{16'd0,      16'd7,      64'd0,        "0x7"});
    vecs.push_back('{16'd1,      16'd1,      64'd1,        "1x1"});
    vecs.push_back('{16'hFFFF,   16'd2,      64'h1FFFE,    "ffffx2"});
    vecs.push_back('{16'd12,     16'd10,     64'd120,      "12x10"});
    vecs.push_back('{16'd100,    16'd1,      64'd100,      "100x1"});
`ifdef REP_MUL_OPSWAP_EN
    vecs.push_back('{16'd0,      16'hFFFF,   64'd0,        "0xffff"});
    vecs.push_back('{16'd2,      16'hFFFF,   64'h1FFFE,    "2xffff"});
`endif

    repeat (3) @(negedge clk);
    chk("rst busy16", 64'(m16.busy), 64'd0);
    chk("rst done16", 64'(m16.done), 64'd0);
    chk("rst prod16", 64'(m16.product), 64'd0);
    chk("rst prod4",  64'(m4.product),  64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst busy16", 64'(m16.busy), 64'd0);

    foreach (vecs[i]) begin
      launch(1'b0, vecs[i].a, vecs[i].b);
      finish(1'b0, 1'b0, vecs[i].name);
      chk({vecs[i].name, " table_prod"}, 64'(m16.product), vecs[i].prod);
      idle_chk(1'b0, vecs[i].name, vecs[i].prod);
    end

    // WIDTH=4 full-scale product, then a start in the DONE cycle.
    launch(1'b1, 16'd15, 16'd15);
    finish(1'b1, 1'b0, "w4_15x15");
    chk("w4_15x15 e1", 64'(m4.product), 64'hE1);
    launch(1'b1, 16'd2, 16'd3);
    finish(1'b1, 1'b0, "w4_b2b");
    idle_chk(1'b1, "w4_b2b", 64'd6);

    // Back-to-back on the wide unit.
    launch(1'b0, 16'd3, 16'd5);
    finish(1'b0, 1'b0, "b2b_a");
    launch(1'b0, 16'd9, 16'd4);
    finish(1'b0, 1'b0, "b2b_b");
    idle_chk(1'b0, "b2b_b", 64'd36);

    // start and operand toggling during RUN must be ignored.
    launch(1'b0, 16'd7, 16'd9);
    finish(1'b0, 1'b1, "noise_7x9");
    idle_chk(1'b0, "noise_7x9", 64'd63);
    repeat (3) @(negedge clk);
    chk("noise held", 64'(m16.product), 64'd63);

    // Reset in cycle 4 of a run aborts it without a done pulse.
    launch(1'b0, 16'd4, 16'd8);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 64'(m16.busy), 64'd0);
    chk("abort done", 64'(m16.done), 64'd0);
    chk("abort prod", 64'(m16.product), 64'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (m16.done || m16.busy) seen_done = 1'b1;
    end
    chk("abort no_done", 64'(seen_done), 64'd0);
    chk("sb empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rep_add_multiplier.md
# rep_add_multiplier

Parametrised unsigned multiplier that computes `a*b` by repeated addition under a start/done handshake. It is the next generation of the team's 16-bit repeated-addition multiplier, generalised in operand width. It has these additions:
- separate operand buses in place of a shared data bus;
- full-width `2*WIDTH` product;
- a reset and a busy flag;
- optional operand swapping that bounds latency by the smaller operand.

It sits as a slave arithmetic unit beside the existing datapath blocks, driven by a host FSM.

## Interface
- `WIDTH`, default 16: operand width in bits, ≥ 2.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  multiplicand; sampled on the accepting edge only.
- `b`  in  WIDTH  multiplier; sampled on the accepting edge only.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; `product` is valid.
- `product`  out  2*WIDTH  result; held until the next accepted start or reset.

## Operation
- State machine: IDLE, RUN, DONE.
- **Reset** (synchronous, priority over everything):
  - state goes to IDLE;
  - `product`, the internal addend, count and accumulator all go to 0;
  - `busy=0`, `done=0`.
- **Accept:** in IDLE or DONE with `start=1`, at that edge:
  - addend ← a;
  - count ← b;
  - accumulator ← 0;
  - state → RUN.
- **RUN, count ≠ 0:** accumulator ← accumulator + zero-extended addend (2*WIDTH bits); count ← count − 1.
- **RUN, count = 0:** `product` ← accumulator; state → DONE.
- **DONE:**
  - `done=1` for exactly this cycle;
  - next state is RUN if `start=1` (accepted, back-to-back), else IDLE.
- `start` during RUN is ignored and has no side effects; `a` and `b` may change freely while busy.
- Arithmetic:
  - unsigned only;
  - accumulator is 2*WIDTH bits, so overflow is impossible;
  - count decrements only while nonzero, so it never wraps.
- `product` is registered and is not updated during RUN, so it keeps the previous result.

## Timing
- Let N be the count loaded at accept: b, or min(a,b) with swap enabled.
- Accept at edge 0 → `busy` high from cycle 1 through cycle N+1.
- `done` is high in cycle N+2, registered, with `product` valid from that cycle on.
- b=0 (or min=0): `done` in cycle 2, `product`=0.
- Back-to-back: a start in the DONE cycle gives `busy` in the next cycle, with no idle gap.
- Reset asserted mid-RUN: the next cycle is IDLE with all outputs 0; no `done` is produced for the aborted operation.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `REP_MUL_OPSWAP_EN` defined:
  - at accept, count ← min(a,b) and addend ← max(a,b);
  - one WIDTH-bit comparator is added on the input side;
  - latency is N = min(a,b).
- `REP_MUL_OPSWAP_EN` undefined: count ← b, addend ← a, and there is no comparator.
- The result is identical in both builds; only latency differs.

## Structure
- Package `rep_mul_pkg` holds:
  - the state encoding typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - a `PROD_W(WIDTH)` width helper constant.
- Sub-module `rep_mul_cntr`:
  - WIDTH-bit loadable down-counter with synchronous reset;
  - ports: load, dec, zero flag;
  - instantiated once for count.
- The top level holds the FSM, addend register, accumulator, adder and product register.

## Test plan
- WIDTH=16, no swap: a=3, b=5, start → `done` in cycle 7, `product`=15; `busy` high in cycles 1–6.
- Same stimulus with `REP_MUL_OPSWAP_EN` defined → `done` in cycle 5, `product`=15.
- b=0, a=0xFFFF → `done` in cycle 2, `product`=0. With swap, a=0, b=0xFFFF → `done` in cycle 2.
- WIDTH=4: a=15, b=15 → `product`=225 (8'hE1), `done` in cycle 17. Then start in the DONE cycle with a=2, b=3 → `done` 5 cycles later, `product`=6.
- a=7, b=9: pulse start again and toggle a/b during RUN → ignored, `product`=63. Then assert `rst` in cycle 4 of a new run (a=4, b=8) → next cycle IDLE, `product`=0, `busy`=0, no `done` pulse.
